// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and helpers for the multi-port register file
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

  // Register 0 is the hardwired-zero register when ZERO_REG is enabled
  localparam int ZERO_ADDR = 0;

  // Address width for a register count; at least one bit so a 1-entry file still has a port
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// rtl/regfile_fwd_mux.sv - per-read-port write forwarding and zero-register select
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     stored,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]     fwd_data
);

  // Scan write ports in ascending order so the highest-numbered matching port wins
  always_comb begin
    fwd_data = stored;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr)) begin
        fwd_data = wr_data[j*XLEN +: XLEN];
      end
    end
    if ((ZERO_REG != 0) && (rd_addr == AW'(ZERO_ADDR))) begin
      fwd_data = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised NRD-read/NWR-write register file, optional REGFILE_SCOREBOARD_EN busy tracking
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NRD-1:0]      rd_busy,
`endif
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: writes applied in port order so port 1 overrides port 0 on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == AW'(ZERO_ADDR)))) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Writes retire their destination; a same-cycle reservation re-marks it for the younger producer
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        busy_next[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en) begin
      busy_next[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_next[ZERO_ADDR] = 1'b0;
    end
  end

  // Busy vector state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] next_data;
    logic [XLEN-1:0] data_q;

    assign addr = rd_addr[i*AW +: AW];

    regfile_fwd_mux #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_fwd (
      .rd_addr  (addr),
      .stored   (regs[addr]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .fwd_data (next_data)
    );

    // Registered read data; disabled ports keep their last value
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (rd_en[i]) begin
        data_q <= next_data;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic busy_q;

    // Busy flag tracks the post-update state and follows the same hold rule as data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy_q <= 1'b0;
      end else if (rd_en[i]) begin
        busy_q <= busy_next[addr];
      end
    end

    assign rd_busy[i] = busy_q;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (2 read, 2 write ports)
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRD-1:0]      rd_en = '0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                rsv_en = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;
`ifdef REGFILE_SCOREBOARD_EN
  logic [NRD-1:0]      rd_busy;
`endif

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef REGFILE_SCOREBOARD_EN
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_busy  (rd_busy),
`endif
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int checks = 0;
  int failures = 0;

  logic [XLEN-1:0] mem    [NREGS];
  logic            mbusy  [NREGS];
  logic [XLEN-1:0] last_d [NRD];
  logic            last_b [NRD];

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      mem[r] = '0;
      mbusy[r] = 1'b0;
    end
    for (int i = 0; i < NRD; i++) begin
      last_d[i] = '0;
      last_b[i] = 1'b0;
    end
  endtask

  task automatic set_idle();
    rd_en = '0;
    wr_en = '0;
    rsv_en = 1'b0;
  endtask

  // One cycle of stimulus; the reference model computes the architectural result and queues it
  task automatic drive(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic rse, input logic [4:0] rsa);
    exp_t e;
    logic [4:0] ra [NRD];
    @(negedge clk);
    rd_en = re;
    rd_addr = {ra1, ra0};
    wr_en = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rsv_en = rse;
    rsv_addr = rsa;
    if (we[0] && wa0 != 5'd0) mem[wa0] = wd0;
    if (we[1] && wa1 != 5'd0) mem[wa1] = wd1;
    if (we[0]) mbusy[wa0] = 1'b0;
    if (we[1]) mbusy[wa1] = 1'b0;
    if (rse) mbusy[rsa] = 1'b1;
    mbusy[0] = 1'b0;
    ra[0] = ra0;
    ra[1] = ra1;
    for (int i = 0; i < NRD; i++) begin
      if (re[i]) begin
        last_d[i] = mem[ra[i]];
        last_b[i] = mbusy[ra[i]];
      end
    end
    e.data = {last_d[1], last_d[0]};
    e.busy = {last_b[1], last_b[0]};
    q.push_back(e);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, NREGS - 1));
  endfunction

  // Monitor: each posedge the DUT presents the result of the queued transaction
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      checks++;
      if (rd_data !== me.data) begin
        failures++;
        $display("FAIL rd_data t=%0t got=%h exp=%h", $time, rd_data, me.data);
      end
`ifdef REGFILE_SCOREBOARD_EN
      checks++;
      if (rd_busy !== me.busy) begin
        failures++;
        $display("FAIL rd_busy t=%0t got=%b exp=%b", $time, rd_busy, me.busy);
      end
`endif
    end
  end

  initial begin
    model_reset();
    // Writes during reset must be dropped
    rd_en = 2'b11;
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd10};
    wr_data = {32'h0, 32'hCAFEF00D};
    repeat (3) @(negedge clk);
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", rd_data);
    end
    set_idle();
    rst_n = 1'b1;

    for (int a = 0; a < NREGS; a++) begin
      drive(2'b11, 5'(a), 5'(NREGS - 1 - a), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    end

    drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 32'h11111111, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(2'b11, 5'd7, 5'd7, 2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(2'b11, 5'd0, 5'd0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    drive(2'b11, 5'd3, 5'd3, 2'b11, 5'd3, 32'hA, 5'd3, 32'hB, 1'b0, 5'd0);
    drive(2'b10, 5'd0, 5'd3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(2'b00, 5'd12, 5'd13, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
    drive(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(2'b11, 5'd9, 5'd9, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(2'b11, 5'd9, 5'd9, 2'b10, 5'd0, 32'h0, 5'd9, 32'h77, 1'b1, 5'd9);
    drive(2'b11, 5'd5, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", rd_data);
    end
`ifdef REGFILE_SCOREBOARD_EN
    checks++;
    if (rd_busy !== '0) begin
      failures++;
      $display("FAIL async_reset_busy got=%b exp=0", rd_busy);
    end
`endif
    model_reset();
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 5'd5, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);

    for (int n = 0; n < 600; n++) begin
      drive(2'($urandom_range(0, 3)), rnd_addr(), rnd_addr(),
            2'($urandom_range(0, 3)), rnd_addr(), $urandom(), rnd_addr(), $urandom(),
            1'($urandom_range(0, 1)), rnd_addr());
    end
    drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
